pet_io_hub: RTL
===============

# pet_io_hub

Parametrised successor to the PET I/O page decoder. It sits between the CPU bus and up to eight peripheral slots (PIAs, VIA, CRTC, expansion devices) and does five things:
- decodes the slot selects,
- paces each access through a small sequencer with per-slot wait states and a `rdy` handshake,
- registers the merged read data,
- adds an IRQ status/mask register,
- aggregates slot interrupts into one `irq`.

## Interface
Parameters:
- `NSLOTS`, 4: number of peripheral slots, 1..8.
- `ADDR_W`, 8: CPU address width inside the I/O page.
- `SEL_LSB`, 4: slot i is selected by `addr[SEL_LSB+i]`. `SEL_LSB+NSLOTS <= ADDR_W` and `SEL_LSB >= 1`.
- `SLOT_WAIT`, 0: packed NSLOTS×4 bits. Nibble i is the wait-state count 0..15 for slot i.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  CPU-cycle clock enable; an access is accepted only on a `clk` edge with `ce`=1.
- `cs`  in  1  I/O page select.
- `we`  in  1  write when 1.
- `addr`  in  `ADDR_W`  page offset.
- `data_in`  in  8  CPU write data.
- `data_out`  out  8  registered read data.
- `rdy`  out  1  1 = hub idle / data valid; 0 = access in progress.
- `slot_strobe`  out  `NSLOTS`  one-clk access strobe per slot.
- `slot_we`  out  1  registered copy of `we` for the current access.
- `slot_addr`  out  `SEL_LSB`  registered `addr[SEL_LSB-1:0]`.
- `slot_wdata`  out  8  registered `data_in`.
- `slot_rdata`  in  `NSLOTS`×8  slot i read data at bits [8i+7:8i].
- `slot_irq`  in  `NSLOTS`  active-high slot interrupt levels.
- `irq`  out  1  aggregated interrupt.

## Operation
- **Select decode:** `sel[i] = cs & addr[SEL_LSB+i]`.
  - Several bits set means a multi-select: all selected slots are strobed and their read data is ANDed together.
  - `cs`=1 with no sel bit set is a control access.
- **Control registers** (addressed by `addr[SEL_LSB-1:0]`; other offsets read FF, writes ignored):
  - Offset 0 is STATUS, read-only: bits[NSLOTS-1:0] are the status bits, upper bits read 1.
  - Offset 1 is MASK, read/write: 1 = enabled; upper bits read 1.
- **`irq`** = |(status & mask), registered.
- **Sequencer** states: IDLE, WAIT, STROBE, CAPTURE.
  - IDLE (`rdy`=1): on `ce & cs`, latch `we`, `addr`, `data_in` and `sel`.
    - If W > 0, go to WAIT; otherwise go to STROBE.
    - W = max `SLOT_WAIT` nibble over the selected slots; W = 0 for control accesses.
  - WAIT: down-counter loaded with W−1; leave for STROBE when the counter reaches 0. WAIT therefore lasts W clks.
  - STROBE: assert `slot_strobe` = latched `sel` for exactly one clk. A control write updates MASK in this cycle.
  - CAPTURE:
    - Read: `data_out` ← AND of the selected `slot_rdata`, or the control register value.
    - Write: `data_out` ← FF.
    - `rdy` returns to 1 and the state returns to IDLE.
- **Busy behaviour:** `cs`/`ce` while `rdy`=0 is ignored, with no queueing. The CPU must stall on `rdy`.
- **Reset values:** state IDLE, `rdy`=1, `slot_strobe`=0, `slot_we`=0, `slot_addr`=0, `slot_wdata`=0, `data_out`=FF, MASK = all ones, status cleared, `irq`=0.
- **Reset mid-access:** the access is aborted and no strobe is issued.

## Timing
- An access is accepted at edge T0. `rdy` is 0 from T0+1.
- `slot_strobe` is high during clk T0+1+W.
- `data_out` is valid and `rdy`=1 at T0+2+W.
- `slot_we`, `slot_addr` and `slot_wdata` are stable from T0+1 until the next acceptance.
- A read sees `slot_rdata` as sampled on the edge ending the STROBE cycle.
- `irq` lags `slot_irq` / mask changes by 1 clk.
- **Back-to-back:** a new access may be accepted in the same clk in which CAPTURE returns `rdy`=1, at the earliest at T0+2+W.

## Configuration
- **`PET_IO_HUB_IRQ_EDGE_EN` defined:**
  - Status bit i is sticky: set on a rising edge of `slot_irq[i]` (previous-sample register).
  - It is cleared by a control write to STATUS with `data_in[i]`=1.
  - Set wins over clear in the same clk.
- **Undefined:** status = registered raw `slot_irq` levels, and STATUS writes are ignored. This is level behaviour, identical to the legacy decoder.

## Test plan
- **Zero-wait read:** NSLOTS=4, `SLOT_WAIT`=0, `slot_rdata`[slot1]=5A; `cs`, `ce`, `addr`=20 read at T0 -> `slot_strobe`=0010 at T0+1, `data_out`=5A with `rdy`=1 at T0+2.
- **Wait states:** slot 2 nibble=3, write `addr`=40, `data_in`=C3 -> `rdy`=0 for 4 clks, strobe 0100 at T0+4 with `slot_we`=1 and `slot_wdata`=C3, `data_out`=FF.
- **Multi-select:** `addr`=30, slot0 data=F0, slot1 data=3C -> both strobed in the same clk, `data_out`=30. An access attempted while `rdy`=0 produces no extra strobe.
- **Mask/irq:** write MASK=02 (`addr`=01); `slot_irq`=0001 -> `irq`=0; `slot_irq`=0010 -> `irq`=1 one clk later. Read MASK returns F2.
- **Edge mode (`PET_IO_HUB_IRQ_EDGE_EN`):** pulse `slot_irq`[3] one clk -> STATUS reads F8 and `irq` stays 1. Write STATUS=08 -> `irq`=0. A pulse in the clear cycle keeps the bit set.
- **Reset mid-access:** assert `reset` during WAIT -> immediately `rdy`=1, no strobe, `data_out`=FF, MASK=FF.

Source files
------------

// File: rtl/pet_io_hub.sv
// PET I/O page slot decoder and access sequencer; access takes 2+W clks, rdy=0 stalls the CPU (no queueing).
// Define PET_IO_HUB_IRQ_EDGE_EN for sticky rising-edge IRQ status bits cleared by STATUS writes.
module pet_io_hub #(
  parameter int NSLOTS = 4,
  parameter int ADDR_W = 8,
  parameter int SEL_LSB = 4,
  parameter logic [NSLOTS*4-1:0] SLOT_WAIT = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  rdy,
  output logic [NSLOTS-1:0]     slot_strobe,
  output logic                  slot_we,
  output logic [SEL_LSB-1:0]    slot_addr,
  output logic [7:0]            slot_wdata,
  input  logic [NSLOTS*8-1:0]   slot_rdata,
  input  logic [NSLOTS-1:0]     slot_irq,
  output logic                  irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STROBE,
    S_CAPTURE
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx, wmax;
  logic [NSLOTS-1:0] sel, sel_q;
  logic [NSLOTS-1:0] mask, mask_nx, status, status_nx;
  logic              accept, ctrl_wr, irq_nx;
  logic [7:0]        ctrl_rdata, slot_and, rd_value;
  logic              unused_addr;

  assign unused_addr = ^addr;
  assign sel         = cs ? addr[SEL_LSB +: NSLOTS] : '0;
  assign rdy         = (state == S_IDLE) || (state == S_CAPTURE);
  assign accept      = rdy && ce && cs;
  assign slot_strobe = (state == S_STROBE) ? sel_q : '0;
  assign ctrl_wr     = (state == S_STROBE) && slot_we && (sel_q == '0);

  // A multi-select waits for its slowest slot.
  always_comb begin
    wmax = 4'd0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (sel[i] && (SLOT_WAIT[4*i +: 4] > wmax)) begin
        wmax = SLOT_WAIT[4*i +: 4];
      end
    end
  end

  // CAPTURE already reports rdy, so it accepts the next access exactly like IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE, S_CAPTURE: begin
        state_nx = S_IDLE;
        if (accept) begin
          if (wmax != 4'd0) begin
            state_nx = S_WAIT;
            cnt_nx   = wmax - 4'd1;
          end else begin
            state_nx = S_STROBE;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_STROBE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_STROBE: state_nx = S_CAPTURE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    slot_and = 8'hFF;
    for (int i = 0; i < NSLOTS; i++) begin
      if (sel_q[i]) begin
        slot_and = slot_and & slot_rdata[8*i +: 8];
      end
    end
    ctrl_rdata = 8'hFF;
    if (slot_addr == SEL_LSB'(0)) begin
      ctrl_rdata[NSLOTS-1:0] = status;
    end else if (slot_addr == SEL_LSB'(1)) begin
      ctrl_rdata[NSLOTS-1:0] = mask;
    end
    rd_value = (sel_q != '0) ? slot_and : ctrl_rdata;
  end

  assign mask_nx = (ctrl_wr && (slot_addr == SEL_LSB'(1))) ? slot_wdata[NSLOTS-1:0] : mask;

`ifdef PET_IO_HUB_IRQ_EDGE_EN
  logic [NSLOTS-1:0] irq_prev, status_clr;

  // Set is OR'ed in after the clear so a new edge survives a simultaneous clear.
  assign status_clr = (ctrl_wr && (slot_addr == SEL_LSB'(0))) ? slot_wdata[NSLOTS-1:0] : '0;
  assign status_nx  = (status & ~status_clr) | (slot_irq & ~irq_prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
    end else begin
      irq_prev <= slot_irq;
    end
  end
`else
  assign status_nx = slot_irq;
`endif

  // irq is built from the next-state status and mask so it lags its sources by one clk.
  assign irq_nx = |(status_nx & mask_nx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      sel_q      <= '0;
      slot_we    <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= 8'h00;
      data_out   <= 8'hFF;
      mask       <= '1;
      status     <= '0;
      irq        <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mask   <= mask_nx;
      status <= status_nx;
      irq    <= irq_nx;
      if (accept) begin
        sel_q      <= sel;
        slot_we    <= we;
        slot_addr  <= addr[SEL_LSB-1:0];
        slot_wdata <= data_in;
      end
      if (state == S_STROBE) begin
        data_out <= slot_we ? 8'hFF : rd_value;
      end
    end
  end

endmodule
